// File: rtl/int_wb_arbiter_pkg.sv
// int_wb_arbiter_pkg: shared integer-core writeback types and default sizing
package int_wb_arbiter_pkg;

    localparam int XLEN           = 64;
    localparam int ROB_W          = 6;
    localparam int IROB_W         = 5;
    localparam int IPR_W          = 7;
    localparam int NUM_FU_DEF     = 4;
    localparam int NUM_WBPORT_DEF = 2;

    typedef logic [ROB_W-1:0]  robIdx_t;
    typedef logic [IROB_W-1:0] irobIdx_t;
    typedef logic [IPR_W-1:0]  iprIdx_t;

    typedef struct packed {
        robIdx_t         rob_idx;
        irobIdx_t        irob_idx;
        logic            use_imm;
        logic            rd_wen;
        iprIdx_t         iprd_idx;
        logic [XLEN-1:0] result;
    } valwbInfo_t;

endpackage

// File: rtl/int_wb_arbiter_rr_multi_grant.sv
// rr_multi_grant: round-robin arbiter granting up to NUM_GNT requesters per cycle
module rr_multi_grant #(
    parameter int NUM_REQ = 4,
    parameter int NUM_GNT = 2
) (
    input  logic [NUM_REQ-1:0]              req,
    input  logic [$clog2(NUM_REQ)-1:0]      ptr,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [NUM_GNT-1:0][NUM_REQ-1:0] sel,
    output logic [$clog2(NUM_REQ)-1:0]      last
);

    localparam int PW = $clog2(NUM_REQ);

    int idx;
    int cnt;

    // Scan from ptr with wrap; the k-th winner drives one-hot select row k
    always_comb begin
        gnt  = '0;
        sel  = '0;
        last = ptr;
        idx  = 0;
        cnt  = 0;
        for (int s = 0; s < NUM_REQ; s++) begin
            idx = int'(ptr) + s;
            if (idx >= NUM_REQ) idx -= NUM_REQ;
            if (req[idx] && cnt < NUM_GNT) begin
                gnt[idx]      = 1'b1;
                sel[cnt][idx] = 1'b1;
                last          = PW'(idx);
                cnt++;
            end
        end
    end

endmodule

// File: rtl/int_wb_arbiter.sv
// int_wb_arbiter: arbitrates integer FU writebacks onto regfile write ports and ROB completion
module int_wb_arbiter
    import int_wb_arbiter_pkg::*;
#(
    parameter int NUM_FU     = NUM_FU_DEF,
    parameter int NUM_WBPORT = NUM_WBPORT_DEF
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_FU-1:0]                     i_wb_vld,
    input  valwbInfo_t [NUM_FU-1:0]               i_wbInfo,
    output logic [NUM_FU-1:0]                     o_wb_stall,
    output logic [NUM_WBPORT-1:0]                 o_wb_vld,
    output valwbInfo_t [NUM_WBPORT-1:0]           o_wbInfo,
    output logic [NUM_WBPORT-1:0]                 o_rf_wen,
    output iprIdx_t [NUM_WBPORT-1:0]              o_rf_widx,
    output logic [NUM_WBPORT-1:0][XLEN-1:0]       o_rf_wdata
);

    localparam int PW = $clog2(NUM_FU);

    logic [PW-1:0]                        rr_ptr;
    logic [PW-1:0]                        last;
    logic [NUM_FU-1:0]                    gnt;
    logic [NUM_WBPORT-1:0][NUM_FU-1:0]    sel;
    valwbInfo_t [NUM_WBPORT-1:0]          pl;

    rr_multi_grant #(
        .NUM_REQ (NUM_FU),
        .NUM_GNT (NUM_WBPORT)
    ) u_rr (
        .req  (i_wb_vld),
        .ptr  (rr_ptr),
        .gnt  (gnt),
        .sel  (sel),
        .last (last)
    );

    // Losers hold their writeback register; nothing stalls while in reset
    assign o_wb_stall = rst ? '0 : i_wb_vld & ~gnt;

    // Route each port's selected FU payload
    always_comb begin
        pl = '0;
        for (int k = 0; k < NUM_WBPORT; k++)
            for (int i = 0; i < NUM_FU; i++)
                if (sel[k][i]) pl[k] = i_wbInfo[i];
    end

    // Register grants; idle ports drop rd_wen but keep the rest of the payload
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_wb_vld <= '0;
            o_wbInfo <= '0;
            rr_ptr   <= '0;
        end else begin
            for (int k = 0; k < NUM_WBPORT; k++) begin
                o_wb_vld[k] <= |sel[k];
                if (|sel[k]) o_wbInfo[k] <= pl[k];
                else o_wbInfo[k].rd_wen <= 1'b0;
            end
            if (|gnt) rr_ptr <= (last == PW'(NUM_FU - 1)) ? '0 : last + 1'b1;
        end
    end

    // Regfile write ports are a view of the registered writeback
    always_comb begin
        for (int j = 0; j < NUM_WBPORT; j++) begin
            o_rf_wen[j]   = o_wb_vld[j] && o_wbInfo[j].rd_wen;
            o_rf_widx[j]  = o_wbInfo[j].iprd_idx;
            o_rf_wdata[j] = o_wbInfo[j].result;
        end
    end

    // Guard against duplicate destination writes and stalls without a request
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_FU; i++) begin
                assert (!(o_wb_stall[i] && !i_wb_vld[i]));
                for (int j = i + 1; j < NUM_FU; j++)
                    assert (!(gnt[i] && gnt[j] && i_wbInfo[i].rd_wen && i_wbInfo[j].rd_wen
                              && i_wbInfo[i].iprd_idx == i_wbInfo[j].iprd_idx));
            end
        end
    end

endmodule
